// File: rtl/branch_resolve_queue_pkg.sv
// Shared types and constants for the branch resolve queue.
// Holds the per-packet entry layout and the per-slot predictor update record.
package branch_resolve_queue_pkg;

   localparam int BRQ_DEPTH = 8;
   localparam int BRQ_PTR_W = 3;

   localparam logic [31:0] SLOT_BYTES = 32'd4;
   localparam logic [31:0] PKT_BYTES  = 32'd8;

   typedef struct packed {
      logic [31:0] pc;
      logic        pt1;
      logic        pt2;
      logic [31:0] pred_addr;
   } bp_entry_t;

   typedef struct packed {
      logic        valid;
      logic        is_bj;
      logic        pred_taken;
      logic [31:0] pc;
      logic        real_taken;
      logic [31:0] real_addr;
      logic [31:0] pred_addr;
   } slot_upd_t;

   function automatic logic [31:0] next_pc(input logic        taken,
                                           input logic [31:0] tgt,
                                           input logic [31:0] fall);
      return taken ? tgt : fall;
   endfunction

endpackage

// File: rtl/brq_fifo.sv
// Generic DEPTH x W circular buffer with synchronous clear; head is read combinationally.
// Push is refused when full (even with a same-cycle pop); clear overrides push and pop.
module brq_fifo #(
   parameter int DEPTH = 8,
   parameter int PTR_W = 3,
   parameter int W     = 66
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clr,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [W-1:0]     i_dat,
   output logic [W-1:0]     o_dat,
   output logic [PTR_W:0]   o_count
);
   logic [W-1:0]     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;

   assign w_full  = (r_count == (PTR_W+1)'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_push  = i_push & ~w_full & ~i_clr;
   assign w_pop   = i_pop & ~w_empty & ~i_clr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
      end
   end

   // Storage carries no reset; only the pointers define what is live.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_dat;
   end

   assign o_dat   = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/branch_resolve_queue.sv
// Carries fetch-packet predictions from IF to EX; resolves head against real outcomes, 1-cycle registered outputs.
// push_ready drops when full; a mispredict or ext_flush empties the queue and drops same-cycle pushes.
module branch_resolve_queue
   import branch_resolve_queue_pkg::*;
#(
   parameter int DEPTH = BRQ_DEPTH,
   parameter int PTR_W = BRQ_PTR_W
) (
   input  logic        cpu_clk,
   input  logic        cpu_rstn,
   input  logic        push_valid,
   output logic        push_ready,
   input  logic [31:0] push_pc,
   input  logic        push_pred_taken1,
   input  logic        push_pred_taken2,
   input  logic [31:0] push_pred_addr,
   input  logic        ex_resolve,
   input  logic        ex_slot_v1,
   input  logic        ex_slot_v2,
   input  logic        ex_is_bj_1,
   input  logic        ex_is_bj_2,
   input  logic        real_taken1,
   input  logic        real_taken2,
   input  logic [31:0] real_tgt1,
   input  logic [31:0] real_tgt2,
   input  logic        ext_flush,
   output logic        upd_valid1,
   output logic        upd_valid2,
   output logic        upd_is_bj_1,
   output logic        upd_is_bj_2,
   output logic        upd_pred_taken1,
   output logic        upd_pred_taken2,
   output logic [31:0] upd_pc_1,
   output logic [31:0] upd_pc_2,
   output logic        upd_real_taken1,
   output logic        upd_real_taken2,
   output logic [31:0] upd_real_addr1,
   output logic [31:0] upd_real_addr2,
   output logic [31:0] upd_pred_addr1,
   output logic [31:0] upd_pred_addr2,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        underflow_err
);
   bp_entry_t      w_push_ent;
   bp_entry_t      w_head;
   logic [PTR_W:0] w_count;
   logic           w_empty;
   logic           w_resolve;
   logic           w_clr;
   logic           w_mis1;
   logic           w_mis2;
   logic [31:0]    w_pc2;
   logic [31:0]    w_fall2;
   logic [31:0]    w_pred1;
   logic [31:0]    w_pred2;
   logic [31:0]    w_real1;
   logic [31:0]    w_real2;

   slot_upd_t      r_upd1;
   slot_upd_t      r_upd2;
   logic           r_redir_v;
   logic [31:0]    r_redir_pc;
   logic           r_underflow;

   assign w_push_ent = '{pc: push_pc, pt1: push_pred_taken1, pt2: push_pred_taken2,
                         pred_addr: push_pred_addr};

   brq_fifo #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W),
      .W     ($bits(bp_entry_t))
   ) u_fifo (
      .clk     (cpu_clk),
      .rst_n   (cpu_rstn),
      .i_clr   (w_clr),
      .i_push  (push_valid & push_ready),
      .i_pop   (w_resolve),
      .i_dat   (w_push_ent),
      .o_dat   (w_head),
      .o_count (w_count)
   );

   assign push_ready = (w_count != (PTR_W+1)'(DEPTH));
   assign w_empty    = (w_count == '0);
   assign w_resolve  = ex_resolve & ~ext_flush & ~w_empty;

   assign w_pc2   = w_head.pc + SLOT_BYTES;
   assign w_fall2 = w_head.pc + PKT_BYTES;
   assign w_pred1 = next_pc(w_head.pt1, w_head.pred_addr, w_pc2);
   assign w_real1 = next_pc(real_taken1, real_tgt1, w_pc2);
   assign w_pred2 = next_pc(w_head.pt2, w_head.pred_addr, w_fall2);
   assign w_real2 = next_pc(real_taken2, real_tgt2, w_fall2);

   // Slot2 only counts as a miss when slot1 did not already redirect the packet.
   assign w_mis1 = ex_slot_v1 & (w_pred1 != w_real1);
   assign w_mis2 = ex_slot_v2 & ~w_mis1 & (w_pred2 != w_real2);
   assign w_clr  = ext_flush | (w_resolve & (w_mis1 | w_mis2));

   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         r_upd1      <= '0;
         r_upd2      <= '0;
         r_redir_v   <= 1'b0;
         r_redir_pc  <= '0;
         r_underflow <= 1'b0;
      end else begin
         if (ex_resolve & ~ext_flush & w_empty) r_underflow <= 1'b1;
         if (w_resolve) begin
            r_upd1 <= '{valid: ex_slot_v1, is_bj: ex_is_bj_1, pred_taken: w_head.pt1,
                        pc: w_head.pc, real_taken: real_taken1, real_addr: w_real1,
                        pred_addr: w_pred1};
            r_upd2 <= '{valid: ex_slot_v2 & ~w_mis1, is_bj: ex_is_bj_2,
                        pred_taken: w_head.pt2, pc: w_pc2, real_taken: real_taken2,
                        real_addr: w_real2, pred_addr: w_pred2};
            r_redir_v  <= w_mis1 | w_mis2;
            r_redir_pc <= w_mis1 ? w_real1 : (w_mis2 ? w_real2 : '0);
         end else begin
            r_upd1     <= '0;
            r_upd2     <= '0;
            r_redir_v  <= 1'b0;
            r_redir_pc <= '0;
         end
      end
   end

   assign upd_valid1      = r_upd1.valid;
   assign upd_is_bj_1     = r_upd1.is_bj;
   assign upd_pred_taken1 = r_upd1.pred_taken;
   assign upd_pc_1        = r_upd1.pc;
   assign upd_real_taken1 = r_upd1.real_taken;
   assign upd_real_addr1  = r_upd1.real_addr;
   assign upd_pred_addr1  = r_upd1.pred_addr;
   assign upd_valid2      = r_upd2.valid;
   assign upd_is_bj_2     = r_upd2.is_bj;
   assign upd_pred_taken2 = r_upd2.pred_taken;
   assign upd_pc_2        = r_upd2.pc;
   assign upd_real_taken2 = r_upd2.real_taken;
   assign upd_real_addr2  = r_upd2.real_addr;
   assign upd_pred_addr2  = r_upd2.pred_addr;
   assign redirect_valid  = r_redir_v;
   assign redirect_pc     = r_redir_pc;
   assign underflow_err   = r_underflow;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: resolve expectations go to a scoreboard queue,
// a negedge monitor pops and compares whenever the DUT shows an update or redirect.
module tb_branch_resolve_queue;

   typedef struct {
      logic        v1;
      logic        v2;
      logic        redir;
      logic [31:0] rpc;
      logic [31:0] pc1;
      logic [31:0] pc2;
      logic [31:0] ra2;
      logic [31:0] pa2;
   } exp_t;

   logic        cpu_clk = 1'b0;
   logic        cpu_rstn = 1'b0;
   logic        push_valid = 1'b0;
   logic        push_ready;
   logic [31:0] push_pc = '0;
   logic        push_pred_taken1 = 1'b0;
   logic        push_pred_taken2 = 1'b0;
   logic [31:0] push_pred_addr = '0;
   logic        ex_resolve = 1'b0;
   logic        ex_slot_v1 = 1'b0;
   logic        ex_slot_v2 = 1'b0;
   logic        ex_is_bj_1 = 1'b0;
   logic        ex_is_bj_2 = 1'b0;
   logic        real_taken1 = 1'b0;
   logic        real_taken2 = 1'b0;
   logic [31:0] real_tgt1 = '0;
   logic [31:0] real_tgt2 = '0;
   logic        ext_flush = 1'b0;
   logic        upd_valid1, upd_valid2, upd_is_bj_1, upd_is_bj_2;
   logic        upd_pred_taken1, upd_pred_taken2, upd_real_taken1, upd_real_taken2;
   logic [31:0] upd_pc_1, upd_pc_2, upd_real_addr1, upd_real_addr2;
   logic [31:0] upd_pred_addr1, upd_pred_addr2;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        underflow_err;

   int   checks = 0;
   int   passed = 0;
   exp_t sb[$];

   branch_resolve_queue dut (
      .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn),
      .push_valid(push_valid), .push_ready(push_ready), .push_pc(push_pc),
      .push_pred_taken1(push_pred_taken1), .push_pred_taken2(push_pred_taken2),
      .push_pred_addr(push_pred_addr),
      .ex_resolve(ex_resolve), .ex_slot_v1(ex_slot_v1), .ex_slot_v2(ex_slot_v2),
      .ex_is_bj_1(ex_is_bj_1), .ex_is_bj_2(ex_is_bj_2),
      .real_taken1(real_taken1), .real_taken2(real_taken2),
      .real_tgt1(real_tgt1), .real_tgt2(real_tgt2), .ext_flush(ext_flush),
      .upd_valid1(upd_valid1), .upd_valid2(upd_valid2),
      .upd_is_bj_1(upd_is_bj_1), .upd_is_bj_2(upd_is_bj_2),
      .upd_pred_taken1(upd_pred_taken1), .upd_pred_taken2(upd_pred_taken2),
      .upd_pc_1(upd_pc_1), .upd_pc_2(upd_pc_2),
      .upd_real_taken1(upd_real_taken1), .upd_real_taken2(upd_real_taken2),
      .upd_real_addr1(upd_real_addr1), .upd_real_addr2(upd_real_addr2),
      .upd_pred_addr1(upd_pred_addr1), .upd_pred_addr2(upd_pred_addr2),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .underflow_err(underflow_err)
   );

   always #5 cpu_clk = ~cpu_clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
   endtask

   function automatic exp_t mk(input logic v1, input logic v2, input logic redir,
                               input logic [31:0] rpc, input logic [31:0] pc1,
                               input logic [31:0] pc2, input logic [31:0] ra2,
                               input logic [31:0] pa2);
      exp_t e;
      e.v1 = v1; e.v2 = v2; e.redir = redir; e.rpc = rpc;
      e.pc1 = pc1; e.pc2 = pc2; e.ra2 = ra2; e.pa2 = pa2;
      return e;
   endfunction

   // All tasks are entered and left 1ns after a rising edge.
   task automatic push(input logic [31:0] pc, input logic pt1, input logic pt2,
                       input logic [31:0] pa);
      push_valid = 1'b1; push_pc = pc;
      push_pred_taken1 = pt1; push_pred_taken2 = pt2; push_pred_addr = pa;
      @(posedge cpu_clk); #1;
      push_valid = 1'b0;
   endtask

   task automatic resolve(input logic v1, input logic v2, input logic rt1, input logic rt2,
                          input logic [31:0] t1, input logic [31:0] t2,
                          input logic flush, input logic wpush);
      ex_resolve = 1'b1; ex_slot_v1 = v1; ex_slot_v2 = v2;
      ex_is_bj_1 = v1; ex_is_bj_2 = v2;
      real_taken1 = rt1; real_taken2 = rt2; real_tgt1 = t1; real_tgt2 = t2;
      ext_flush = flush;
      if (wpush) begin
         push_valid = 1'b1; push_pc = 32'hdead0000;
         push_pred_taken1 = 1'b0; push_pred_taken2 = 1'b0; push_pred_addr = 32'hdead0008;
      end
      @(posedge cpu_clk); #1;
      ex_resolve = 1'b0; ext_flush = 1'b0; push_valid = 1'b0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge cpu_clk);
         if (upd_valid1 || upd_valid2 || redirect_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_output", {29'd0, upd_valid1, upd_valid2, redirect_valid}, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("upd_valid1", {31'd0, upd_valid1}, {31'd0, e.v1});
               chk("upd_valid2", {31'd0, upd_valid2}, {31'd0, e.v2});
               chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, e.redir});
               if (e.redir) chk("redirect_pc", redirect_pc, e.rpc);
               if (e.v1) chk("upd_pc_1", upd_pc_1, e.pc1);
               if (e.v2) begin
                  chk("upd_pc_2", upd_pc_2, e.pc2);
                  chk("upd_real_addr2", upd_real_addr2, e.ra2);
                  chk("upd_pred_addr2", upd_pred_addr2, e.pa2);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [31:0] pc;
      #1;
      chk("rst_push_ready", {31'd0, push_ready}, 32'd1);
      chk("rst_upd_valid1", {31'd0, upd_valid1}, 32'd0);
      chk("rst_redirect", {31'd0, redirect_valid}, 32'd0);
      chk("rst_underflow", {31'd0, underflow_err}, 32'd0);
      chk("rst_count", 32'(dut.w_count), 32'd0);
      repeat (2) @(posedge cpu_clk);
      #1 cpu_rstn = 1'b1;

      // Correct prediction, both slots fall through.
      push(32'h1c000000, 1'b0, 1'b0, 32'h1c000008);
      sb.push_back(mk(1, 1, 0, 0, 32'h1c000000, 32'h1c000004, 32'h1c000008, 32'h1c000008));
      resolve(1, 1, 0, 0, 0, 0, 0, 0);
      chk("t1_count", 32'(dut.w_count), 32'd0);

      // Slot1 mispredict: flushes queue, squashes slot2, drops same-cycle push.
      push(32'h1c000020, 1'b1, 1'b0, 32'h1c000100);
      push(32'h1c000030, 1'b0, 1'b0, 32'h1c000038);
      sb.push_back(mk(1, 0, 1, 32'h1c000200, 32'h1c000020, 0, 0, 0));
      resolve(1, 1, 1, 0, 32'h1c000200, 0, 0, 1);
      chk("t2_count", 32'(dut.w_count), 32'd0);
      chk("t2_push_ready", {31'd0, push_ready}, 32'd1);

      // Slot2 mispredict.
      push(32'h1c000010, 1'b0, 1'b0, 32'h1c000018);
      sb.push_back(mk(1, 1, 1, 32'h1c000040, 32'h1c000010, 32'h1c000014,
                      32'h1c000040, 32'h1c000018));
      resolve(1, 1, 0, 1, 0, 32'h1c000040, 0, 0);
      chk("t3_count", 32'(dut.w_count), 32'd0);

      // pc+4 / pc+8 wrap at the top of the address space.
      push(32'hfffffffc, 1'b0, 1'b0, 32'h00000004);
      sb.push_back(mk(1, 1, 0, 0, 32'hfffffffc, 32'h00000000, 32'h00000004, 32'h00000004));
      resolve(1, 1, 0, 0, 0, 0, 0, 0);

      // Fill to full, then 9th push with simultaneous resolve.
      for (int i = 0; i < 8; i++) push(32'h1c001000 + 32'(i * 8), 1'b0, 1'b0,
                                       32'h1c001008 + 32'(i * 8));
      chk("full_push_ready", {31'd0, push_ready}, 32'd0);
      chk("full_count", 32'(dut.w_count), 32'd8);
      sb.push_back(mk(1, 1, 0, 0, 32'h1c001000, 32'h1c001004, 32'h1c001008, 32'h1c001008));
      resolve(1, 1, 0, 0, 0, 0, 0, 1);
      chk("full9_count", 32'(dut.w_count), 32'd7);
      chk("full9_push_ready", {31'd0, push_ready}, 32'd1);

      // Drain four entries in order, leaving three.
      for (int i = 1; i <= 4; i++) begin
         pc = 32'h1c001000 + 32'(i * 8);
         sb.push_back(mk(1, 1, 0, 0, pc, pc + 32'd4, pc + 32'd8, pc + 32'd8));
         resolve(1, 1, 0, 0, 0, 0, 0, 0);
      end
      chk("drain_count", 32'(dut.w_count), 32'd3);

      // ext_flush wins over a same-cycle (mispredicting) resolve and push.
      resolve(1, 1, 1, 0, 32'h1c00beef, 0, 1, 1);
      chk("flush_count", 32'(dut.w_count), 32'd0);
      chk("flush_push_ready", {31'd0, push_ready}, 32'd1);
      @(negedge cpu_clk);
      chk("flush_upd_valid1", {31'd0, upd_valid1}, 32'd0);
      chk("flush_redirect", {31'd0, redirect_valid}, 32'd0);
      @(posedge cpu_clk); #1;

      // Resolve on empty queue.
      resolve(1, 1, 0, 0, 0, 0, 0, 0);
      chk("uf_err", {31'd0, underflow_err}, 32'd1);
      @(negedge cpu_clk);
      chk("uf_upd_valid1", {31'd0, upd_valid1}, 32'd0);
      chk("uf_upd_valid2", {31'd0, upd_valid2}, 32'd0);
      repeat (3) @(posedge cpu_clk);
      #1 chk("uf_sticky", {31'd0, underflow_err}, 32'd1);

      // Async reset while an update pulse is showing and one entry remains.
      push(32'h1c000300, 1'b0, 1'b0, 32'h1c000308);
      push(32'h1c000308, 1'b0, 1'b0, 32'h1c000310);
      resolve(1, 0, 0, 0, 0, 0, 0, 0);
      chk("pre_rst_upd_valid1", {31'd0, upd_valid1}, 32'd1);
      chk("pre_rst_count", 32'(dut.w_count), 32'd1);
      #2 cpu_rstn = 1'b0;
      #1;
      chk("arst_upd_valid1", {31'd0, upd_valid1}, 32'd0);
      chk("arst_upd_pc_1", upd_pc_1, 32'd0);
      chk("arst_underflow", {31'd0, underflow_err}, 32'd0);
      chk("arst_count", 32'(dut.w_count), 32'd0);
      chk("arst_push_ready", {31'd0, push_ready}, 32'd1);
      @(posedge cpu_clk); #1 cpu_rstn = 1'b1;
      repeat (2) @(posedge cpu_clk);
      #1 chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
